mod7_serial_tx: RTL and testbench
=================================

# mod7_serial_tx

Serial frame transmitter that pairs with the team's serial mod-7 residue receiver. It accepts a parallel word over a valid/ready handshake and shifts it out MSB first on a single-bit line. It then appends a 3-bit check symbol equal to the word's value mod 7, so the downstream residue receiver can be driven and checked end to end. It sits between a parallel producer (bench driver or register block) and the `data_in` pin of the receiver.

## Interface
- `DATA_W`, default 16: data word width in bits. Legal range is 3..64.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load_valid`  in  1: producer has a word on `load_data`.
- `load_data`  in  `DATA_W`: word to transmit.
- `load_ready`  out  1: transmitter can accept a word. High only in IDLE.
- `data_out`  out  1: serial bit. Registered. 0 whenever `frame_out` = 0.
- `frame_out`  out  1: `data_out` carries a frame bit this cycle. Registered.
- `residue_out`  out  3: running residue, mod 7, of the data bits already shifted out in the current frame. Registered.
- `done`  out  1: one-cycle pulse in the GAP cycle after the last check bit.

## Operation
- **States:** IDLE, DATA, CHECK, GAP.
- **IDLE:**
  - `load_ready` = 1.
  - On the rising edge where `load_valid` && `load_ready`: capture `load_data` into the shift register, clear the residue, move to DATA.
  - In the same edge, set `data_out` to `load_data[DATA_W-1]` and `frame_out` to 1.
- **DATA:** `DATA_W` cycles, one bit per cycle, MSB first.
  - At the end of each DATA cycle: residue <= (2·residue + `data_out`) mod 7. Then shift.
  - Residue is always in 0..6. The value 7 is unreachable.
  - At the edge leaving the last DATA cycle, compute the final residue R. Load R into the 3-bit check register. Drive `data_out` = R[2]. Move to CHECK.
- **CHECK:** 3 cycles driving R[2], R[1], R[0].
  - `residue_out` holds R and does not change.
  - After the third cycle, move to GAP.
- **GAP:** 1 cycle.
  - `frame_out` = 0, `data_out` = 0, `done` = 1, `residue_out` = R.
  - Next state is IDLE.
- `load_valid` outside IDLE is ignored. The word is not captured, and the producer must hold it until `load_ready`.
- `load_data` changes while `load_ready` = 0 have no effect.

## Timing
- **Reset values:** state IDLE, `load_ready` 1, `data_out` 0, `frame_out` 0, `residue_out` 0, `done` 0. Shift and check registers are cleared.
- **Latency:** the first data bit appears on `data_out` in the cycle right after the accepting edge.
- **Frame length:** `frame_out` is high for exactly `DATA_W`+3 consecutive cycles.
- **Period:** back-to-back words give one frame per `DATA_W`+5 cycles (accept cycle + data + check + GAP). `load_ready` rises the cycle after GAP.
- **`residue_out`** updates one edge after the corresponding data bit's cycle. After the k-th data bit it equals the first k bits, read as a binary number, mod 7.
- **Reset mid-frame:** all outputs go to their reset values immediately, without waiting for `clk`. No partial check symbol is sent. The first edge after release is in IDLE.
- **Accept during release:** `load_valid` asserted during the same cycle that reset is released is accepted on the first rising edge with `rst_n` = 1.
- **Done pulse:** `done` never overlaps `frame_out`.

## Structure
- **Shared package `mod7_pkg`:**
  - State enum constants (IDLE, DATA, CHECK, GAP).
  - `CHK_W` = 3.
  - `MOD7_STEP(r, b)` residue-step function, to be reused by the receiver and the bench model.
- **Sub-module `mod7_accum`:**
  - Registered 3-bit residue with `clr` and `en` inputs and bit input `b`.
  - Exposes both the current and the next residue.
  - Instantiated once. The top FSM uses the next-residue output to load the check register at the DATA→CHECK edge.
- **Top:** FSM, bit counter of width `$clog2(DATA_W)`, `DATA_W`-bit shift register, 3-bit check shift register.

## Test plan
- **Basic frame:** `DATA_W`=16, reset, load 16'd100.
  - Serial stream is 0000000001100100 then 010.
  - `frame_out` high for 19 cycles, `done` pulses once, `residue_out` = 2.
- **Boundary values:**
  - 16'hFFFF → check 001, `residue_out` = 1.
  - 16'd7 → check 000.
  - 16'd1000 → check 110.
  - Confirm the residue never reads 7.
- **Back-to-back:** hold `load_valid` with words 16'd100 then 16'd1000.
  - The second accept occurs exactly 21 cycles after the first.
  - Exactly one GAP cycle separates the frames.
- **Busy-time load:** toggle `load_valid` and `load_data` during DATA.
  - Frame content is unchanged.
  - `load_ready` stays 0 until IDLE.
- **Reset mid-frame:** pull `rst_n` low on data bit 8.
  - `frame_out`, `data_out`, `residue_out` drop to 0 before the next edge.
  - After release, a new load of 16'd100 produces a clean 19-cycle frame.
- **Loop-back:** feed `data_out` into the mod-7 receiver for 2000 random words.
  - The receiver's output matches the bench model `MOD7_STEP` on every cycle.
  - `residue_out` at GAP equals word mod 7.

Source files
------------

// File: rtl/mod7_pkg.sv
// Shared definitions for the mod-7 serial link: FSM states, check-symbol width
// and the residue step used by transmitter, receiver and bench models.
package mod7_pkg;

  localparam int CHK_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Appending bit b to a prefix with residue r gives (2r + b) mod 7; 2r + b <= 13.
  function automatic logic [CHK_W-1:0] MOD7_STEP(input logic [CHK_W-1:0] r, input logic b);
    logic [CHK_W:0] v;
    v = {r, b};
    return CHK_W'((v >= 4'd7) ? (v - 4'd7) : v);
  endfunction

endpackage

// File: rtl/mod7_serial_tx_if.sv
// Parallel load handshake between a word producer and the mod-7 serial transmitter.
interface mod7_serial_tx_if #(
  parameter int DATA_W = 16
);

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/mod7_accum.sv
// Registered running residue mod 7 of a serial bit stream, MSB first.
// The next-state value is exported so the owner can capture the final residue on the last bit.
module mod7_accum
  import mod7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             b_i,
  output logic [CHK_W-1:0] res_o,
  output logic [CHK_W-1:0] res_next_o
);

  logic [CHK_W-1:0] res_q;
  logic [CHK_W-1:0] res_d;

  // Clear wins over accumulate so a new frame always starts from zero.
  always_comb begin
    res_d = res_q;
    if (clr_i) begin
      res_d = 3'd0;
    end else if (en_i) begin
      res_d = MOD7_STEP(res_q, b_i);
    end else begin
      res_d = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 3'd0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o      = res_q;
  assign res_next_o = res_d;

endmodule

// File: rtl/mod7_serial_tx.sv
// Serial frame transmitter: shifts a parallel word out MSB first, then appends
// its 3-bit residue mod 7 as a check symbol, followed by one idle GAP cycle.
module mod7_serial_tx
  import mod7_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mod7_serial_tx_if.slave        load_if,
  output logic                   data_out,
  output logic                   frame_out,
  output logic [CHK_W-1:0]       residue_out,
  output logic                   done
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic               data_q, data_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               acc_clr_s;
  logic               acc_en_s;
  logic [CHK_W-1:0]   acc_res_s;
  logic [CHK_W-1:0]   acc_next_s;

  mod7_accum u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (acc_clr_s),
    .en_i       (acc_en_s),
    .b_i        (data_q),
    .res_o      (acc_res_s),
    .res_next_o (acc_next_s)
  );

  // Shift and check registers keep the next bit to send in their MSB.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    data_d    = data_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    acc_clr_s = 1'b0;
    acc_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_if.load_valid && ready_q) begin
          state_d   = DATA;
          shift_d   = {load_if.load_data[DATA_W-2:0], 1'b0};
          cnt_d     = '0;
          data_d    = load_if.load_data[DATA_W-1];
          frame_d   = 1'b1;
          acc_clr_s = 1'b1;
        end else begin
          data_d  = 1'b0;
          frame_d = 1'b0;
        end
      end
      DATA: begin
        acc_en_s = 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = CHECK;
          chk_d   = {acc_next_s[1:0], 1'b0};
          data_d  = acc_next_s[2];
          cnt_d   = '0;
        end else begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          data_d  = shift_q[DATA_W-1];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (cnt_q == CNT_W'(2)) begin
          state_d = GAP;
          data_d  = 1'b0;
          frame_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          chk_d  = {chk_q[1:0], 1'b0};
          data_d = chk_q[2];
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        data_d  = 1'b0;
        frame_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      chk_q   <= 3'd0;
      data_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign load_if.load_ready = ready_q;
  assign data_out           = data_q;
  assign frame_out          = frame_q;
  assign residue_out        = acc_res_s;
  assign done               = done_q;

endmodule

// File: tb/tb_mod7_serial_tx.sv
// Self-checking bench for mod7_serial_tx: directed table, back-to-back, busy-load,
// mid-frame reset and random words against an arithmetic prefix-mod-7 model.
module tb_mod7_serial_tx;

  localparam int W = 16;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  chk_r;
    int          mode;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_out;
  logic       frame_out;
  logic       done;
  logic [2:0] residue_out;
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  logic       saw_seven = 1'b0;

  mod7_serial_tx_if #(.DATA_W(W)) load_if ();

  mod7_serial_tx #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_if     (load_if),
    .data_out    (data_out),
    .frame_out   (frame_out),
    .residue_out (residue_out),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (residue_out == 3'd7) saw_seven <= 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Value of the first k transmitted bits, read as a binary number, mod 7.
  function automatic int prefix_mod7(input logic [15:0] w, input int k);
    int kk;
    kk = (k > W) ? W : k;
    return (int'(w) >> (W - kk)) % 7;
  endfunction

  // mode 0: drop valid after accept; 1: random valid/data during frame; 2: hold valid, present nxt
  task automatic run_frame(input logic [15:0] w, input logic [2:0] exp_r, input int mode,
                           input logic [15:0] nxt, output int acc_cyc);
    int waited;
    logic exp_bit;
    waited = 0;
    while (load_if.load_ready !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_load", 32'(load_if.load_ready), 32'd1);
    load_if.load_valid = 1'b1;
    load_if.load_data  = w;
    @(negedge clk);
    acc_cyc = cyc;
    for (int k = 0; k < W + 3; k++) begin
      if (k < W) exp_bit = w[W-1-k];
      else       exp_bit = exp_r[2-(k-W)];
      chk("frame_high", 32'(frame_out), 32'd1);
      chk("data_bit", 32'(data_out), 32'(exp_bit));
      chk("residue", 32'(residue_out), prefix_mod7(w, k));
      chk("done_in_frame", 32'(done), 32'd0);
      chk("ready_busy", 32'(load_if.load_ready), 32'd0);
      if (mode == 0 && k == 0) begin
        load_if.load_valid = 1'b0;
      end else if (mode == 1) begin
        if (k < W + 2) begin
          load_if.load_valid = 1'($urandom_range(0, 1));
          load_if.load_data  = 16'($urandom);
        end else begin
          load_if.load_valid = 1'b0;
        end
      end else if (mode == 2 && k == 0) begin
        load_if.load_data = nxt;
      end
      @(negedge clk);
    end
    chk("gap_frame", 32'(frame_out), 32'd0);
    chk("gap_data", 32'(data_out), 32'd0);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_residue", 32'(residue_out), 32'(exp_r));
    chk("gap_ready", 32'(load_if.load_ready), 32'd0);
    @(negedge clk);
    chk("idle_ready", 32'(load_if.load_ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_frame", 32'(frame_out), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int a0;
    int a1;
    logic [15:0] w;

    vecs[0] = '{16'd100,   3'd2, 0};
    vecs[1] = '{16'hFFFF,  3'd1, 0};
    vecs[2] = '{16'd7,     3'd0, 0};
    vecs[3] = '{16'd1000,  3'd6, 0};
    vecs[4] = '{16'd0,     3'd0, 1};
    vecs[5] = '{16'h8000,  3'd1, 1};

    rst_n = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.load_data  = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(load_if.load_ready), 32'd1);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_frame", 32'(frame_out), 32'd0);
    chk("rst_residue", 32'(residue_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].word, vecs[i].chk_r, vecs[i].mode, 16'd0, a0);
    end

    run_frame(16'd100, 3'd2, 2, 16'd1000, a0);
    run_frame(16'd1000, 3'd6, 0, 16'd0, a1);
    chk("b2b_period", 32'(a1 - a0), 32'd21);

    load_if.load_valid = 1'b1;
    load_if.load_data  = 16'hFFFF;
    @(negedge clk);
    load_if.load_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_frame", 32'(frame_out), 32'd1);
    chk("pre_rst_residue", 32'(residue_out), prefix_mod7(16'hFFFF, 8));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_frame", 32'(frame_out), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_residue", 32'(residue_out), 32'd0);
    chk("mid_rst_ready", 32'(load_if.load_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(16'd100, 3'd2, 0, 16'd0, a0);

    for (int n = 0; n < 2000; n++) begin
      w = 16'($urandom);
      run_frame(w, 3'(int'(w) % 7), int'($urandom_range(0, 1)), 16'd0, a0);
    end

    chk("never_seven", 32'(saw_seven), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
